// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce.
// Drives one column low at a time, samples the synchronised rows at the end
// of each column slot, and classifies every full scan as none/single/multi.
// A four-state FSM accepts a press or a release only after DEBOUNCE_SCANS
// identical results, so is_pressed rises exactly once per physical press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] button,
  output logic       is_pressed
);

  localparam int              SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_LAST   = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} result_t;

  logic [3:0]        row_meta;
  logic [3:0]        row_sync;
  logic [1:0]        col_idx;
  logic [SLOT_W-1:0] slot;
  logic              sample;
  logic [1:0]        acc_count;
  logic [3:0]        acc_code;
  logic [2:0]        low_count;
  logic [1:0]        low_row;
  logic [2:0]        total_count;
  logic [3:0]        code_now;
  logic              scan_done;
  result_t           scan_result;
  logic [3:0]        scan_code;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cand;
  logic [3:0]        cand_next;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic [3:0]        cnt_inc;
  logic [3:0]        button_next;
  logic              is_pressed_next;

  // Key legend, indexed by row and column.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hF;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hE;
      default: key_code = 4'hD;
    endcase
  endfunction

  assign sample  = (slot == SLOT_LAST);
  assign col     = ~(4'b0001 << col_idx);
  assign cnt_inc = cnt + 4'd1;

  // Two-flop synchroniser; idle rows read as all released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Column slot timer: hold each column for SCAN_DIV cycles, then advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot    <= '0;
      col_idx <= 2'd0;
    end else if (sample) begin
      slot    <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      slot    <= slot + SLOT_W'(1);
    end
  end

  // Count low rows in the current column and pick the key if only one is low.
  always_comb begin
    low_count = 3'd0;
    low_row   = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) begin
        low_count = low_count + 3'd1;
        low_row   = 2'(r);
      end
    end
    total_count = {1'b0, acc_count} + low_count;
    code_now    = (low_count == 3'd1) ? key_code(low_row, col_idx) : acc_code;
  end

  // Accumulate per-column samples; publish one classified result per scan.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_count   <= 2'd0;
      acc_code    <= 4'd0;
      scan_done   <= 1'b0;
      scan_result <= RES_NONE;
      scan_code   <= 4'd0;
    end else begin
      scan_done <= 1'b0;
      if (sample) begin
        if (col_idx == 2'd3) begin
          scan_done <= 1'b1;
          scan_code <= code_now;
          if (total_count == 3'd0) begin
            scan_result <= RES_NONE;
          end else if (total_count == 3'd1) begin
            scan_result <= RES_SINGLE;
          end else begin
            scan_result <= RES_MULTI;
          end
          acc_count <= 2'd0;
          acc_code  <= 4'd0;
        end else begin
          acc_count <= (total_count >= 3'd2) ? 2'd2 : total_count[1:0];
          acc_code  <= code_now;
        end
      end
    end
  end

  // Debounce FSM state and its registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cand       <= 4'd0;
      cnt        <= 4'd0;
      button     <= 4'd0;
      is_pressed <= 1'b0;
    end else begin
      state      <= state_next;
      cand       <= cand_next;
      cnt        <= cnt_next;
      button     <= button_next;
      is_pressed <= is_pressed_next;
    end
  end

  // Next-state decision, taken only when a full scan has completed.
  always_comb begin
    state_next = state;
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (scan_result == RES_SINGLE) state_next = DB_PRESS;
        end
        DB_PRESS: begin
          if (scan_result != RES_SINGLE) begin
            state_next = IDLE;
          end else if (scan_code == cand && cnt_inc == DB_LAST) begin
            state_next = PRESSED;
          end
        end
        PRESSED: begin
          if (scan_result == RES_NONE) state_next = DB_RELEASE;
        end
        DB_RELEASE: begin
          if (scan_result != RES_NONE) begin
            state_next = PRESSED;
          end else if (cnt_inc == DB_LAST) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Candidate, debounce count and output updates for each transition.
  always_comb begin
    cand_next       = cand;
    cnt_next        = cnt;
    button_next     = button;
    is_pressed_next = is_pressed;
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (scan_result == RES_SINGLE) begin
            cand_next = scan_code;
            cnt_next  = 4'd1;
          end
        end
        DB_PRESS: begin
          if (scan_result == RES_SINGLE) begin
            if (scan_code == cand) begin
              cnt_next = cnt_inc;
              if (cnt_inc == DB_LAST) begin
                button_next     = cand;
                is_pressed_next = 1'b1;
              end
            end else begin
              cand_next = scan_code;
              cnt_next  = 4'd1;
            end
          end
        end
        PRESSED: begin
          if (scan_result == RES_NONE) cnt_next = 4'd1;
        end
        DB_RELEASE: begin
          if (scan_result == RES_NONE) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB_LAST) is_pressed_next = 1'b0;
          end
        end
        default: begin
          cnt_next = 4'd0;
        end
      endcase
    end
  end

endmodule
